// File: rtl/wdf_sample_feeder.sv
// -----------------------------------------------------------------------------
// wdf_sample_feeder
//
// Sample-issue stage between the test pattern generator and the WDF core.
// Incoming samples are buffered in a small FIFO and handed to the core one at
// a time with a start/done handshake. Each core result is captured and
// presented as a one-cycle out_valid pulse.
//
// Optional feature macro: WDF_FEEDER_TIMEOUT_EN
//   Defined   : a WAIT-state watchdog aborts a sample after TIMEOUT_CYCLES
//               cycles without core_done and sets the sticky timeout flag.
//   Undefined : WAIT waits indefinitely; timeout is tied to 0.
//
// Parameters
//   DATA_W         sample / result width (two's complement)
//   FIFO_DEPTH     input buffer entries (power of 2, >= 2)
//   TIMEOUT_CYCLES WAIT-state watchdog limit (only used with the macro)
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   in_valid      upstream sample strobe (one sample per high cycle)
//   in_data       upstream sample
//   in_ready      FIFO not full (advisory; upstream is never stalled)
//   core_x        sample presented to the core, stable until the next pop
//   core_start    one-cycle start pulse to the core
//   core_done     core result-valid pulse
//   core_y        core result, valid with core_done
//   out_valid     one-cycle pulse, result captured
//   out_data      captured result, held until the next capture
//   sample_count  results captured since reset (wraps)
//   overflow      sticky: a sample was dropped because the FIFO was full
//   timeout       sticky: the core failed to respond in time
//   busy          FSM not idle or FIFO non-empty
// -----------------------------------------------------------------------------
module wdf_sample_feeder #(
  parameter int DATA_W         = 16,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] core_x,
  output logic              core_start,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_y,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       sample_count,
  output logic              overflow,
  output logic              timeout,
  output logic              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Elaboration-time guard on the configuration.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("wdf_sample_feeder: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // FIFO storage and pointers; the extra MSB distinguishes full from empty.
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic              w_capture;
  logic              w_to_hit;

  logic [DATA_W-1:0] r_core_x;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [31:0]       r_sample_count;
  logic              r_overflow;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Fullness is judged from registered pointers only, so a push that lands
  // on the same edge as a pop from a full FIFO is still dropped.
  assign w_push = in_valid & ~w_full;
  assign w_drop = in_valid &  w_full;

  // ---------------------------------------------------------------------------
  // Optional WAIT-state watchdog
  // ---------------------------------------------------------------------------
`ifdef WDF_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] r_to_cnt;
  logic          r_timeout;
  logic          w_expire;

  assign w_to_hit = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_expire = (r_state == S_WAIT) && !core_done && w_to_hit;

  // Held at zero outside WAIT, so every entry into WAIT starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else if (w_expire) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_to_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking (<=) so every register samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      // core_done during ISSUE is deliberately ignored.
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_to_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; validity is tracked purely by the
  // pointers, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_core_x       <= '0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_sample_count <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_out_valid <= w_capture;
      if (w_pop) begin
        r_core_x <= r_mem[r_rd_ptr[AW-1:0]];
      end
      if (w_capture) begin
        r_out_data     <= core_y;
        r_sample_count <= r_sample_count + 32'd1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all derived from registered state)
  // ---------------------------------------------------------------------------
  assign core_x       = r_core_x;
  assign core_start   = (r_state == S_ISSUE);
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign sample_count = r_sample_count;
  assign overflow     = r_overflow;
  assign in_ready     = ~w_full;
  assign busy         = (r_state != S_IDLE) | ~w_empty;

endmodule

// File: tb/tb_wdf_sample_feeder.sv
// -----------------------------------------------------------------------------
// tb_wdf_sample_feeder
//
// Bench for wdf_sample_feeder. A behavioural core model answers core_start
// with the nibble-reversed sample after a programmable latency (and can be
// held or abandoned). A scoreboard queues each accepted sample in push order;
// the monitor checks every core_start against it and queues the expected core
// result, which is checked on every out_valid pulse.
// -----------------------------------------------------------------------------
module tb_wdf_sample_feeder;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic [DATA_W-1:0] core_x;
  logic              core_start;
  logic              core_done;
  logic [DATA_W-1:0] core_y;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [31:0]       sample_count;
  logic              overflow;
  logic              timeout;
  logic              busy;

  // Core model state, plus a manual done path for the reset test.
  logic              model_done = 1'b0;
  logic [DATA_W-1:0] model_y = '0;
  logic              man_done = 1'b0;
  logic [DATA_W-1:0] man_y = '0;
  logic              core_hold = 1'b0;
  int                core_lat = 3;
  int                epoch = 0;

  assign core_done = model_done | man_done;
  assign core_y    = man_done ? man_y : model_y;

  int total = 0;
  int bad   = 0;
  int n_start = 0;
  int n_out   = 0;

  logic [DATA_W-1:0] exp_x[$];
  logic [DATA_W-1:0] exp_y[$];

  wdf_sample_feeder #(
    .DATA_W        (DATA_W),
    .FIFO_DEPTH    (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .core_x      (core_x),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_y      (core_y),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .sample_count(sample_count),
    .overflow    (overflow),
    .timeout     (timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rev_nib(input logic [DATA_W-1:0] v);
    return {v[3:0], v[7:4], v[11:8], v[15:12]};
  endfunction

  // Core model: on core_start, wait while held, then core_lat cycles, then a
  // one-cycle done with the nibble-reversed sample. A reset bumps epoch and
  // abandons any answer in progress.
  initial begin
    logic [DATA_W-1:0] x;
    int                ep;
    forever begin
      @(negedge clk);
      if (core_start && !reset) begin
        ep = epoch;
        x  = core_x;
        while (core_hold && ep == epoch) @(negedge clk);
        repeat (core_lat) @(negedge clk);
        if (ep == epoch) begin
          model_done = 1'b1;
          model_y    = rev_nib(x);
          @(negedge clk);
          model_done = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard comparisons for every issue and every capture.
  task automatic monitor();
    logic [DATA_W-1:0] ex;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (core_start) begin
          n_start++;
          total++;
          if (exp_x.size() == 0) begin
            bad++;
            $display("FAIL core_x_order: unexpected issue of %h, nothing queued", core_x);
          end else begin
            ex = exp_x.pop_front();
            exp_y.push_back(rev_nib(ex));
            if (core_x !== ex) begin
              bad++;
              $display("FAIL core_x_order: got %h want %h", core_x, ex);
            end
          end
        end
        if (out_valid) begin
          n_out++;
          total++;
          if (exp_y.size() == 0) begin
            bad++;
            $display("FAIL out_data_order: unexpected out_valid with %h", out_data);
          end else begin
            ex = exp_y.pop_front();
            if (out_data !== ex) begin
              bad++;
              $display("FAIL out_data_order: got %h want %h", out_data, ex);
            end
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    man_done = 1'b0;
    epoch++;
    exp_x.delete();
    exp_y.delete();
    repeat (2) @(negedge clk);
    n_start = 0;
    n_out   = 0;
    reset   = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_one(input logic [DATA_W-1:0] v, input bit accept);
    in_valid = 1'b1;
    in_data  = v;
    if (accept) exp_x.push_back(v);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_start(input string name, input int budget);
    int cyc = 0;
    while (!core_start && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (!core_start) begin
      bad++;
      $display("FAIL %s: no core_start within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int cyc = 0;
    while ((busy || exp_x.size() != 0 || exp_y.size() != 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc >= budget) begin
      bad++;
      $display("FAIL %s: not drained after %0d cycles (busy=%b pending_x=%0d pending_y=%0d)",
               name, budget, busy, exp_x.size(), exp_y.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (core_start !== 1'b0) begin bad++; $display("FAIL reset_core_start: got %b want 0", core_start); end
    total++; if (core_x !== '0)      begin bad++; $display("FAIL reset_core_x: got %h want 0", core_x); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== '0)    begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    total++; if (sample_count !== 32'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", sample_count); end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    total++; if (timeout !== 1'b0)   begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
  endtask

  // Single sample with exact issue timing: push at edge k, pop at k+1,
  // core_start visible in the cycle after k+1.
  task automatic test_single();
    core_lat = 3;
    push_one(16'h1234, 1'b1);
    total++; if (core_start !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL single_after_push: core_start=%b busy=%b want 0/1", core_start, busy);
    end
    @(negedge clk);
    total++; if (core_start !== 1'b1) begin bad++; $display("FAIL single_start_timing: got %b want 1", core_start); end
    total++; if (core_x !== 16'h1234) begin bad++; $display("FAIL single_core_x: got %h want 1234", core_x); end
    wait_drain("single_drain", 50);
    total++; if (n_start != 1) begin bad++; $display("FAIL single_starts: got %0d want 1", n_start); end
    total++; if (n_out != 1) begin bad++; $display("FAIL single_out_pulses: got %0d want 1", n_out); end
    total++; if (out_data !== 16'h4321) begin bad++; $display("FAIL single_out_data: got %h want 4321", out_data); end
    total++; if (sample_count !== 32'd1) begin bad++; $display("FAIL single_count: got %0d want 1", sample_count); end
  endtask

  task automatic test_burst();
    core_lat = 10;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(i);
      exp_x.push_back(DATA_W'(i));
      @(negedge clk);
    end
    in_valid = 1'b0;
    // One sample already went to the core, so seven remain: not full.
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL burst_in_ready: got %b want 1", in_ready); end
    wait_drain("burst_drain", 400);
    total++; if (n_out != 9) begin bad++; $display("FAIL burst_results: got %0d want 9", n_out); end
    total++; if (sample_count !== 32'd9) begin bad++; $display("FAIL burst_count: got %0d want 9", sample_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL burst_overflow: got %b want 0", overflow); end
  endtask

  // Core stalled on one sample; eight more fill the FIFO, the next is dropped.
  task automatic test_overflow();
    do_reset();
    core_lat  = 2;
    core_hold = 1'b1;
    push_one(16'hA000, 1'b1);
    wait_start("ovf_first_issue", 10);
    for (int i = 1; i <= 9; i++) begin
      if (i == 9) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ovf_in_ready_full: got %b want 0", in_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before_drop: got %b want 0", overflow); end
      end
      in_valid = 1'b1;
      in_data  = 16'hA000 + DATA_W'(i);
      if (i < 9) exp_x.push_back(16'hA000 + DATA_W'(i));
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
    core_hold = 1'b0;
    wait_drain("ovf_drain", 200);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    total++; if (sample_count !== 32'd9) begin bad++; $display("FAIL ovf_count: got %0d want 9", sample_count); end
  endtask

  // Push on the very edge that pops a full FIFO: dropped, count ends at 7.
  task automatic test_push_pop_full();
    int cyc = 0;
    do_reset();
    core_lat  = 2;
    core_hold = 1'b1;
    push_one(16'hB000, 1'b1);
    wait_start("ppf_first_issue", 10);
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hB000 + DATA_W'(i);
      exp_x.push_back(16'hB000 + DATA_W'(i));
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL ppf_full_state: in_ready=%b overflow=%b want 0/0", in_ready, overflow);
    end
    core_hold = 1'b0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    total++; if (!out_valid) begin bad++; $display("FAIL ppf_capture: no out_valid within 50 cycles"); end
    // FSM is now IDLE with a full FIFO: the next edge pops.
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (core_start !== 1'b1) begin bad++; $display("FAIL ppf_pop: core_start got %b want 1", core_start); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ppf_overflow: got %b want 1", overflow); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ppf_count7: in_ready got %b want 1", in_ready); end
    wait_drain("ppf_drain", 200);
    total++; if (sample_count !== 32'd9) begin bad++; $display("FAIL ppf_count: got %0d want 9", sample_count); end
  endtask

  task automatic test_reset_mid_wait();
    int outs_before;
    do_reset();
    core_hold = 1'b1;
    push_one(16'hC0DE, 1'b1);
    wait_start("rmw_issue", 10);
    @(negedge clk);
    reset = 1'b1;
    #1;
    // Asynchronous: reset values must appear before any clock edge.
    total++; if (core_x !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmw_async: core_x=%h busy=%b want 0/0", core_x, busy);
    end
    epoch++;
    exp_y.delete();
    @(negedge clk);
    reset     = 1'b0;
    core_hold = 1'b0;
    outs_before = n_out;
    man_y    = 16'h7777;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (n_out != outs_before) begin bad++; $display("FAIL rmw_no_out: got %0d pulses want 0", n_out - outs_before); end
    total++; if (sample_count !== 32'd0) begin bad++; $display("FAIL rmw_count: got %0d want 0", sample_count); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL rmw_out_data: got %h want 0", out_data); end
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rmw_idle: busy=%b in_ready=%b want 0/1", busy, in_ready);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    core_lat  = 2;
    core_hold = 1'b1;
    push_one(16'hD001, 1'b1);
    wait_start("to_issue", 10);
`ifdef WDF_FEEDER_TIMEOUT_EN
    repeat (16) @(negedge clk);
    total++; if (timeout !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL to_early: timeout=%b busy=%b want 0/1", timeout, busy);
    end
    @(negedge clk);
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_set: got %b want 1", timeout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle: busy got %b want 0", busy); end
    epoch++;
    exp_y.delete();
    core_hold = 1'b0;
    push_one(16'hD002, 1'b1);
    wait_drain("to_recover", 50);
    total++; if (n_out != 1 || sample_count !== 32'd1) begin
      bad++; $display("FAIL to_recover_count: pulses=%0d count=%0d want 1/1", n_out, sample_count);
    end
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", timeout); end
`else
    repeat (40) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL no_to_busy: got %b want 1", busy); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL no_to_flag: got %b want 0", timeout); end
    core_hold = 1'b0;
    wait_drain("no_to_release", 50);
    total++; if (sample_count !== 32'd1) begin bad++; $display("FAIL no_to_count: got %0d want 1", sample_count); end
`endif
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_push_pop_full();
    test_reset_mid_wait();
    test_timeout();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
